mc_control_fsm: RTL and testbench

- Multi-cycle control unit driving the datapath: sequences each instruction through IF/ID/EXE/MEM/WB.
- Generates ALUSrc/ALUop for the downstream ALU, plus PC, register-file, memory and extender controls.
- Consumes the ALU's zero, condition and overflow flags.
- Sits between the instruction register (opcode/func source) and the datapath.

---
 rtl/mc_control_fsm_pkg.sv | 74 +++++++
 rtl/mc_ctrl_decode.sv | 101 ++++++++++
 rtl/mc_control_fsm.sv | 103 ++++++++++
 tb/tb_mc_control_fsm.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_control_fsm_pkg.sv
// Shared definitions for the multi-cycle control unit: instruction codes, state encodings,
// datapath select codes and an opcode classifier used by both the FSM and the decoder.
package mc_control_fsm_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBgtz  = 6'h07;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAddiu = 6'h09;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpHalt  = 6'h3F;

  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSubu = 6'h23;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnSlt  = 6'h2A;

  typedef enum logic [2:0] {
    StIf    = 3'b000,
    StId    = 3'b001,
    StExeLs = 3'b010,
    StMem   = 3'b011,
    StWbLd  = 3'b100,
    StExeBr = 3'b101,
    StExeAl = 3'b110,
    StWbAl  = 3'b111
  } state_e;

  localparam logic [1:0] AluOpAdd = 2'b00;
  localparam logic [1:0] AluOpSub = 2'b01;
  localparam logic [1:0] AluOpOr  = 2'b10;

  localparam logic [1:0] RegDst31 = 2'b00;
  localparam logic [1:0] RegDstRt = 2'b01;
  localparam logic [1:0] RegDstRd = 2'b10;

  localparam logic [1:0] WrSrcAlu = 2'b00;
  localparam logic [1:0] WrSrcMem = 2'b01;
  localparam logic [1:0] WrSrcPc4 = 2'b10;

  localparam logic [1:0] PcSrcSeq    = 2'b00;
  localparam logic [1:0] PcSrcBranch = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  typedef enum logic [2:0] {
    ClsNop,
    ClsJump,
    ClsHalt,
    ClsBranch,
    ClsLdSt,
    ClsAlu
  } op_class_e;

  // Unknown opcodes and unknown R-type funcs both collapse to a nop.
  function automatic op_class_e op_class(logic [5:0] op, logic [5:0] fn);
    op_class_e cls;
    case (op)
      OpRtype: cls = (fn inside {FnAddu, FnSubu, FnSlt, FnOr}) ? ClsAlu : ClsNop;
      OpAddi, OpAddiu, OpOri, OpLui: cls = ClsAlu;
      OpBeq, OpBgtz: cls = ClsBranch;
      OpLw, OpSw: cls = ClsLdSt;
      OpJ, OpJal: cls = ClsJump;
      OpHalt: cls = ClsHalt;
      default: cls = ClsNop;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control decode: maps the current state, instruction fields and ALU flags onto
// the datapath control lines.
module mc_ctrl_decode
  import mc_control_fsm_pkg::*;
(
  input  state_e      state,
  input  logic        halted,
  input  logic [5:0]  OpCode,
  input  logic [5:0]  func,
  input  logic        zero,
  input  logic        condition,
  input  logic        overflow,
  output logic        PCWre,
  output logic        IRWre,
  output logic        ALUSrc,
  output logic [1:0]  ALUop,
  output logic        ExtSel,
  output logic        RegWre,
  output logic [1:0]  RegDst,
  output logic [1:0]  WrRegSrc,
  output logic        mRD,
  output logic        mWR,
  output logic [1:0]  PCSrc
);

  op_class_e cls;

  always_comb begin
    cls      = op_class(OpCode, func);
    PCWre    = 1'b0;
    IRWre    = 1'b0;
    ALUSrc   = 1'b0;
    ALUop    = AluOpAdd;
    ExtSel   = 1'b0;
    RegWre   = 1'b0;
    RegDst   = RegDst31;
    WrRegSrc = WrSrcAlu;
    mRD      = 1'b0;
    mWR      = 1'b0;
    PCSrc    = PcSrcSeq;

    // ALU controls track the held instruction once it has been fetched.
    if (state != StIf) begin
      ALUSrc = OpCode inside {OpAddi, OpAddiu, OpOri, OpLui, OpLw, OpSw};
      ExtSel = (OpCode != OpOri);
      if (OpCode == OpRtype) begin
        if (func == FnSubu || func == FnSlt) ALUop = AluOpSub;
        else if (func == FnOr)               ALUop = AluOpOr;
      end else if (OpCode == OpBeq) begin
        ALUop = AluOpSub;
      end else if (OpCode == OpOri) begin
        ALUop = AluOpOr;
      end
    end

    unique case (state)
      StIf: IRWre = 1'b1;
      StId: begin
        if (!halted) begin
          if (cls == ClsJump) begin
            PCWre = 1'b1;
            PCSrc = PcSrcJump;
            if (OpCode == OpJal) begin
              RegWre   = 1'b1;
              RegDst   = RegDst31;
              WrRegSrc = WrSrcPc4;
            end
          end else if (cls == ClsNop) begin
            PCWre = 1'b1;
          end
        end
      end
      StExeBr: begin
        PCWre = 1'b1;
        if ((OpCode == OpBeq && zero) || (OpCode == OpBgtz && condition)) PCSrc = PcSrcBranch;
      end
      StMem: begin
        if (OpCode == OpLw) begin
          mRD = 1'b1;
        end else begin
          mWR   = 1'b1;
          PCWre = 1'b1;
        end
      end
      StWbLd: begin
        PCWre    = 1'b1;
        RegWre   = 1'b1;
        RegDst   = RegDstRt;
        WrRegSrc = WrSrcMem;
      end
      StWbAl: begin
        PCWre    = 1'b1;
        RegWre   = !(OpCode == OpAddi && overflow);
        RegDst   = (OpCode == OpRtype) ? RegDstRd : RegDstRt;
        WrRegSrc = WrSrcAlu;
      end
      StExeLs, StExeAl: ;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control FSM: state register, halt flag and decoder instance.
// Define MC_CTRL_PERF_CNT_EN to add the cycle_cnt / instr_cnt performance counters.
module mc_control_fsm
  import mc_control_fsm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  OpCode,
  input  logic [5:0]  func,
  input  logic        zero,
  input  logic        condition,
  input  logic        overflow,
  output logic [2:0]  state,
  output logic        PCWre,
  output logic        IRWre,
  output logic        ALUSrc,
  output logic [1:0]  ALUop,
  output logic        ExtSel,
  output logic        RegWre,
  output logic [1:0]  RegDst,
  output logic [1:0]  WrRegSrc,
  output logic        mRD,
  output logic        mWR,
  output logic [1:0]  PCSrc
`ifdef MC_CTRL_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);

  state_e state_q, state_d;
  logic   halted_q, halted_d;

  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    if (!halted_q) begin
      unique case (state_q)
        StIf: state_d = StId;
        StId: begin
          case (op_class(OpCode, func))
            ClsHalt:   halted_d = 1'b1;
            ClsBranch: state_d  = StExeBr;
            ClsLdSt:   state_d  = StExeLs;
            ClsAlu:    state_d  = StExeAl;
            default:   state_d  = StIf;
          endcase
        end
        StExeLs: state_d = StMem;
        StMem:   state_d = (OpCode == OpLw) ? StWbLd : StIf;
        StExeAl: state_d = StWbAl;
        StWbLd, StExeBr, StWbAl: state_d = StIf;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIf;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  assign state = state_q;

  mc_ctrl_decode u_decode (
    .state     (state_q),
    .halted    (halted_q),
    .OpCode    (OpCode),
    .func      (func),
    .zero      (zero),
    .condition (condition),
    .overflow  (overflow),
    .PCWre     (PCWre),
    .IRWre     (IRWre),
    .ALUSrc    (ALUSrc),
    .ALUop     (ALUop),
    .ExtSel    (ExtSel),
    .RegWre    (RegWre),
    .RegDst    (RegDst),
    .WrRegSrc  (WrRegSrc),
    .mRD       (mRD),
    .mWR       (mWR),
    .PCSrc     (PCSrc)
  );

`ifdef MC_CTRL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (!halted_q) cycle_cnt <= cycle_cnt + 32'd1;
      if (PCWre)     instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized self-checking bench for mc_control_fsm against a per-instruction cycle model.
module tb_mc_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  OpCode, func;
  logic        zero, condition, overflow;
  logic [2:0]  state;
  logic        PCWre, IRWre, ALUSrc, ExtSel, RegWre, mRD, mWR;
  logic [1:0]  ALUop, RegDst, WrRegSrc, PCSrc;
`ifdef MC_CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int exp_cyc = 0;
  int exp_ins = 0;

  localparam logic [17:0] ResetVec = 18'h02000;  // state IF, IRWre only

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .OpCode    (OpCode),
    .func      (func),
    .zero      (zero),
    .condition (condition),
    .overflow  (overflow),
    .state     (state),
    .PCWre     (PCWre),
    .IRWre     (IRWre),
    .ALUSrc    (ALUSrc),
    .ALUop     (ALUop),
    .ExtSel    (ExtSel),
    .RegWre    (RegWre),
    .RegDst    (RegDst),
    .WrRegSrc  (WrRegSrc),
    .mRD       (mRD),
    .mWR       (mWR),
    .PCSrc     (PCSrc)
`ifdef MC_CTRL_PERF_CNT_EN
    ,
    .cycle_cnt (cycle_cnt),
    .instr_cnt (instr_cnt)
`endif
  );

  logic [17:0] obs;
  assign obs = {state, PCWre, IRWre, ALUSrc, ALUop, ExtSel, RegWre, RegDst, WrRegSrc,
                mRD, mWR, PCSrc};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Instruction kinds: 0 nop, 1 j, 2 jal, 3 branch, 4 lw, 5 sw, 6 alu
  function automatic int kind_of(logic [5:0] op, logic [5:0] fn);
    case (op)
      6'h00:               return (fn == 6'h21 || fn == 6'h23 || fn == 6'h2A || fn == 6'h25) ? 6 : 0;
      6'h08, 6'h09, 6'h0D, 6'h0F: return 6;
      6'h04, 6'h07:        return 3;
      6'h23:               return 4;
      6'h2B:               return 5;
      6'h02:               return 1;
      6'h03:               return 2;
      default:             return 0;
    endcase
  endfunction

  function automatic int len_of(int kind);
    case (kind)
      3:       return 3;
      4:       return 5;
      5, 6:    return 4;
      default: return 2;
    endcase
  endfunction

  // Expected outputs for cycle k of an instruction, from the per-instruction timeline.
  function automatic logic [17:0] model(logic [5:0] op, logic [5:0] fn, int k,
                                         logic z, logic c, logic v);
    int kind = kind_of(op, fn);
    int len  = len_of(kind);
    logic [2:0] st;
    logic pcw, irw, asrc, ext, rw, rd, wr;
    logic [1:0] aop, dst, wsrc, psrc;
    st = 3'd0; asrc = 0; ext = 0; aop = 0; rw = 0; rd = 0; wr = 0; dst = 0; wsrc = 0; psrc = 0;
    if (k == 1) st = 3'd1;
    if (k == 2) st = (kind == 3) ? 3'd5 : (kind == 6) ? 3'd6 : 3'd2;
    if (k == 3) st = (kind == 6) ? 3'd7 : 3'd3;
    if (k == 4) st = 3'd4;
    irw = (k == 0);
    pcw = (k == len - 1);
    if (k > 0) begin
      asrc = (op == 6'h08 || op == 6'h09 || op == 6'h0D || op == 6'h0F ||
              op == 6'h23 || op == 6'h2B);
      ext  = (op != 6'h0D);
      if ((op == 6'h00 && (fn == 6'h23 || fn == 6'h2A)) || op == 6'h04) aop = 2'b01;
      if ((op == 6'h00 && fn == 6'h25) || op == 6'h0D) aop = 2'b10;
    end
    if (kind inside {1, 2} && k == 1) psrc = 2'b10;
    if (kind == 2 && k == 1) begin rw = 1; dst = 2'b00; wsrc = 2'b10; end
    if (kind == 3 && k == 2 && ((op == 6'h04 && z) || (op == 6'h07 && c))) psrc = 2'b01;
    if (kind == 4 && k == 3) rd = 1;
    if (kind == 5 && k == 3) wr = 1;
    if (kind == 4 && k == 4) begin rw = 1; dst = 2'b01; wsrc = 2'b01; end
    if (kind == 6 && k == 3) begin
      rw   = !(op == 6'h08 && v);
      dst  = (op == 6'h00) ? 2'b10 : 2'b01;
      wsrc = 2'b00;
    end
    return {st, pcw, irw, asrc, aop, ext, rw, dst, wsrc, rd, wr, psrc};
  endfunction

  // Runs one instruction; rnd picks fresh flags every cycle, abort_at>=0 resets mid-instruction.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input logic c, input logic v, input bit rnd,
                           input int abort_at);
    int len = len_of(kind_of(op, fn));
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      OpCode = op;
      func   = fn;
      if (rnd) begin
        zero = 1'($urandom); condition = 1'($urandom); overflow = 1'($urandom);
      end else begin
        zero = z; condition = c; overflow = v;
      end
      #1;
      check_eq($sformatf("%s.c%0d", tag, k), 32'(obs),
               32'(model(op, fn, k, zero, condition, overflow)));
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_eq({tag, ".abort"}, 32'(obs), 32'(ResetVec));
        exp_cyc = 0;
        exp_ins = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        return;
      end
      exp_cyc++;
    end
    exp_ins++;
  endtask

  logic [5:0] tbl_op [16] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0D,
                              6'h0F, 6'h04, 6'h07, 6'h23, 6'h2B, 6'h02, 6'h03, 6'h11};
  logic [5:0] tbl_fn [16] = '{6'h21, 6'h23, 6'h2A, 6'h25, 6'h00, 6'h15, 6'h2A, 6'h01,
                              6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

  initial begin
    rst_n = 1'b0;
    OpCode = 6'h00; func = 6'h21; zero = 0; condition = 0; overflow = 0;
    #2;
    check_eq("reset", 32'(obs), 32'(ResetVec));
    @(posedge clk);
    #1 rst_n = 1'b1;

    run_instr("addu",    6'h00, 6'h21, 0, 0, 0, 0, -1);
    run_instr("beq_t",   6'h04, 6'h00, 1, 0, 0, 0, -1);
    run_instr("beq_nt",  6'h04, 6'h00, 0, 1, 0, 0, -1);
    run_instr("bgtz_t",  6'h07, 6'h00, 0, 1, 0, 0, -1);
    run_instr("lw",      6'h23, 6'h00, 0, 0, 0, 0, -1);
    run_instr("sw",      6'h2B, 6'h00, 0, 0, 0, 0, -1);
    run_instr("addi_ov", 6'h08, 6'h00, 0, 0, 1, 0, -1);
    run_instr("addiu",   6'h09, 6'h00, 0, 0, 1, 0, -1);
    run_instr("ori",     6'h0D, 6'h00, 0, 0, 0, 0, -1);
    run_instr("jal",     6'h03, 6'h00, 0, 0, 0, 0, -1);
    run_instr("badfn",   6'h00, 6'h3E, 0, 0, 0, 0, -1);

    for (int i = 0; i < 80; i++) begin
      int idx = int'($urandom_range(0, 15));
      run_instr($sformatf("rnd%0d", i), tbl_op[idx], tbl_fn[idx], 0, 0, 0, 1, -1);
    end

`ifdef MC_CTRL_PERF_CNT_EN
    @(negedge clk);
    #1;
    check_eq("cycle_cnt", cycle_cnt, 32'(exp_cyc));
    check_eq("instr_cnt", instr_cnt, 32'(exp_ins));
    exp_cyc++;
`endif

    run_instr("lw_abort", 6'h23, 6'h00, 0, 0, 0, 0, 3);
    run_instr("post_abort", 6'h00, 6'h25, 0, 0, 0, 0, -1);

    // halt: IF, ID, then frozen with state reading ID
    @(negedge clk);
    OpCode = 6'h3F; func = 6'h00;
    #1;
    check_eq("halt.if", 32'({state, IRWre, PCWre}), 32'({3'd0, 1'b1, 1'b0}));
    exp_cyc++;
    @(negedge clk);
    #1;
    check_eq("halt.id", 32'({state, PCWre, RegWre}), 32'({3'd1, 1'b0, 1'b0}));
    exp_cyc++;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      zero = 1'($urandom); condition = 1'($urandom); overflow = 1'($urandom);
      #1;
      check_eq($sformatf("halted%0d", i), 32'({state, PCWre, RegWre, mRD, mWR}),
               32'({3'd1, 4'b0000}));
    end
`ifdef MC_CTRL_PERF_CNT_EN
    check_eq("cycle_cnt_halt", cycle_cnt, 32'(exp_cyc));
`endif
    #2 rst_n = 1'b0;
    #1;
    check_eq("halt.reset", 32'(obs), 32'(ResetVec));
`ifdef MC_CTRL_PERF_CNT_EN
    check_eq("cnt_reset", cycle_cnt | instr_cnt, 32'd0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_instr("post_halt", 6'h0F, 6'h00, 0, 0, 0, 0, -1);
    run_instr("j",         6'h02, 6'h00, 0, 0, 0, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
